// File: rtl/pe_ctrl_sequencer_if.sv
// pe_ctrl_sequencer_if: groups the configuration bus and the PE ctrl
// handshake of pe_ctrl_sequencer. With PE_SEQ_PERF_EN defined the
// stall_cycles performance counter is also carried.
interface pe_ctrl_sequencer_if #(
  parameter int CTRL_W = 11,
  parameter int ADDR_W = 4
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CTRL_W-1:0] cfg_data;
  logic              start;
  logic [ADDR_W-1:0] last_pc;
  logic [7:0]        iter;
  logic              abort;
  logic              pe_ready;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
`ifdef PE_SEQ_PERF_EN
  logic [15:0]       stall_cycles;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, last_pc, iter, abort, pe_ready,
    input  ctrl, ctrl_valid, pc, busy, done, stall_cycles
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, last_pc, iter, abort, pe_ready,
    output ctrl, ctrl_valid, pc, busy, done, stall_cycles
  );
`else
  modport master (
    output cfg_we, cfg_addr, cfg_data, start, last_pc, iter, abort, pe_ready,
    input  ctrl, ctrl_valid, pc, busy, done
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, last_pc, iter, abort, pe_ready,
    output ctrl, ctrl_valid, pc, busy, done
  );
`endif
endinterface

// File: rtl/pe_ctrl_sequencer.sv
// pe_ctrl_sequencer: holds a small program of PE control words and issues
// them one per accepted handshake, repeating the program iter times.
// Optional macro PE_SEQ_PERF_EN adds the stall_cycles counter.
module pe_ctrl_sequencer #(
  parameter int CTRL_W = 11,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_ctrl_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg;
  logic [CTRL_W-1:0] mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_reg;
  logic              ctrl_valid_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] last_pc_reg;
  logic [7:0]        iter_cnt_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [ADDR_W-1:0] pc_inc;
  logic              issue;
  logic              at_last;

  assign pc_inc  = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign issue   = ctrl_valid_reg && bus.pe_ready;
  assign at_last = (pc_reg == last_pc_reg);

  // Program memory write port; only open in IDLE, and start takes priority.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.cfg_we && !bus.start)
      mem[bus.cfg_addr] <= bus.cfg_data;
  end

  // Sequencer FSM; ctrl doubles as the registered read port of the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ctrl_reg       <= '0;
      ctrl_valid_reg <= 1'b0;
      pc_reg         <= '0;
      last_pc_reg    <= '0;
      iter_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            last_pc_reg  <= bus.last_pc;
            iter_cnt_reg <= bus.iter;
            busy_reg     <= 1'b1;
            if (bus.iter == 8'd0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg      <= RUN;
              pc_reg         <= '0;
              ctrl_reg       <= mem[{ADDR_W{1'b0}}];
              ctrl_valid_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_reg      <= IDLE;
            ctrl_valid_reg <= 1'b0;
            pc_reg         <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
          end else if (issue) begin
            if (!at_last) begin
              pc_reg   <= pc_inc;
              ctrl_reg <= mem[pc_inc];
            end else if (iter_cnt_reg > 8'd1) begin
              // Wrap straight to the next pass with no bubble.
              iter_cnt_reg <= iter_cnt_reg - 8'd1;
              pc_reg       <= '0;
              ctrl_reg     <= mem[{ADDR_W{1'b0}}];
            end else begin
              iter_cnt_reg   <= iter_cnt_reg - 8'd1;
              ctrl_valid_reg <= 1'b0;
              state_reg      <= DONE;
              done_reg       <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (bus.abort) begin
            ctrl_valid_reg <= 1'b0;
            pc_reg         <= '0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          ctrl_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
          done_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl       = ctrl_reg;
  assign bus.ctrl_valid = ctrl_valid_reg;
  assign bus.pc         = pc_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

`ifdef PE_SEQ_PERF_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of RUN cycles where a live word is held back by the PE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == RUN && ctrl_valid_reg && !bus.pe_ready &&
                 stall_cnt_reg != 16'hFFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// tb_pe_ctrl_sequencer: directed stimulus with a scoreboard. Stimulus pushes
// expected issues {ctrl, pc, cycle offset} and done offsets into queues; a
// monitor pops and compares at each negedge where the DUT issues or pulses done.
module tb_pe_ctrl_sequencer;
  localparam int CTRL_W = 11;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_ctrl_sequencer_if #(.CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) bus ();

  pe_ctrl_sequencer #(.CTRL_W(CTRL_W), .DEPTH(16), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] pc;
    int                off;
  } issue_t;

  issue_t exp_q[$];
  int     done_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_issue(input logic [CTRL_W-1:0] c, input logic [ADDR_W-1:0] p, input int off);
    issue_t e;
    e.ctrl = c;
    e.pc   = p;
    e.off  = off;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [CTRL_W-1:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] lp, input logic [7:0] it);
    bus.start   = 1'b1;
    bus.last_pc = lp;
    bus.iter    = it;
    start_cyc   = cyc;
    step();
    bus.start   = 1'b0;
    bus.cfg_we  = 1'b0;
    $display("run start last_pc=%0d iter=%0d", lp, it);
  endtask

  task automatic wait_idle(input string name, input int exp_off);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        seen = 1'b1;
        check({name, "_idle_offset"}, cyc - start_cyc, exp_off);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout busy still high after 1000 cycles", name);
    end
    check({name, "_pending_issues"}, exp_q.size(), 0);
    check({name, "_pending_done"}, done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic basic_expect();
    push_issue(11'h504, 4'd0, 1);
    push_issue(11'h68A, 4'd1, 2);
    push_issue(11'h4B3, 4'd2, 3);
    done_q.push_back(4);
  endtask

  // Monitor: compares every issue and done pulse against the queues.
  initial begin
    issue_t e;
    int     d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.ctrl_valid && bus.pe_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue got ctrl=%h pc=%0d exp=none", bus.ctrl, bus.pc);
          end else begin
            e = exp_q.pop_front();
            check("issue", {1'b0, bus.ctrl, bus.pc, 16'(cyc - start_cyc)},
                  {1'b0, e.ctrl, e.pc, 16'(e.off)});
            $display("issue ctrl=%h pc=%0d off=%0d", bus.ctrl, bus.pc, cyc - start_cyc);
          end
        end
        if (bus.done) begin
          if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done got off=%0d exp=none", cyc - start_cyc);
          end else begin
            d = done_q.pop_front();
            check("done_offset", cyc - start_cyc, d);
            check("done_busy", {31'd0, bus.busy}, 32'd1);
            $display("done off=%0d", cyc - start_cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [CTRL_W-1:0] v;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.last_pc = '0; bus.iter = '0;
    bus.abort = 1'b0; bus.pe_ready = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_ctrl", {21'd0, bus.ctrl}, 32'd0);
    check("rst_valid", {31'd0, bus.ctrl_valid}, 32'd0);
    check("rst_pc", {28'd0, bus.pc}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef PE_SEQ_PERF_EN
    check("rst_stall", {16'd0, bus.stall_cycles}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    wr(4'd0, 11'h504);
    wr(4'd1, 11'h68A);
    wr(4'd2, 11'h4B3);

    // Basic run.
    basic_expect();
    start_run(4'd2, 8'd1);
    wait_idle("basic", 5);

    // Two passes back to back.
    push_issue(11'h504, 4'd0, 1); push_issue(11'h68A, 4'd1, 2); push_issue(11'h4B3, 4'd2, 3);
    push_issue(11'h504, 4'd0, 4); push_issue(11'h68A, 4'd1, 5); push_issue(11'h4B3, 4'd2, 6);
    done_q.push_back(7);
    start_run(4'd2, 8'd2);
    wait_idle("repeat", 8);

    // Backpressure: three stalled cycles on 0x68A.
    push_issue(11'h504, 4'd0, 1);
    push_issue(11'h68A, 4'd1, 5);
    push_issue(11'h4B3, 4'd2, 6);
    done_q.push_back(7);
    start_run(4'd2, 8'd1);
    step();
    bus.pe_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold", {17'd0, bus.ctrl, bus.pc}, {17'd0, 11'h68A, 4'd1});
      check("stall_valid", {31'd0, bus.ctrl_valid}, 32'd1);
      step();
    end
    bus.pe_ready = 1'b1;
    wait_idle("backpressure", 8);
`ifdef PE_SEQ_PERF_EN
    check("stall_cycles", {16'd0, bus.stall_cycles}, 32'd3);
`endif

    // iter=0: done immediately, nothing issued.
    done_q.push_back(1);
    start_run(4'd2, 8'd0);
    wait_idle("iter0", 2);

    // Writes during RUN are ignored.
    basic_expect();
    start_run(4'd2, 8'd1);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_data = 11'h000;
    step();
    step();
    bus.cfg_we = 1'b0;
    wait_idle("we_in_run", 5);
    basic_expect();
    start_run(4'd2, 8'd1);
    wait_idle("rerun_after_we", 5);

    // start and cfg_we together: write dropped.
    basic_expect();
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 11'h7FF;
    start_run(4'd2, 8'd1);
    wait_idle("start_we", 5);
    basic_expect();
    start_run(4'd2, 8'd1);
    wait_idle("rerun_after_start_we", 5);

    // Single-word program, three passes.
    push_issue(11'h504, 4'd0, 1); push_issue(11'h504, 4'd0, 2); push_issue(11'h504, 4'd0, 3);
    done_q.push_back(4);
    start_run(4'd0, 8'd3);
    wait_idle("last_pc0", 5);

    // Abort while pc=1; the coincident issue still counts.
    push_issue(11'h504, 4'd0, 1);
    push_issue(11'h68A, 4'd1, 2);
    start_run(4'd2, 8'd1);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_valid", {31'd0, bus.ctrl_valid}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_pc", {28'd0, bus.pc}, 32'd0);
    wait_idle("abort", 3);
    repeat (3) step();

    // Async reset while pc=1.
    push_issue(11'h504, 4'd0, 1);
    start_run(4'd2, 8'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {21'd0, bus.ctrl}, 32'd0);
    check("midrst_valid", {31'd0, bus.ctrl_valid}, 32'd0);
    check("midrst_pc", {28'd0, bus.pc}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
`ifdef PE_SEQ_PERF_EN
    check("midrst_stall", {16'd0, bus.stall_cycles}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("midrst_pending_issues", exp_q.size(), 0);
    check("midrst_pending_done", done_q.size(), 0);
    exp_q.delete();
    done_q.delete();

    // Full memory, last_pc=15.
    for (int i = 0; i < 16; i++) begin
      v = CTRL_W'((i * 37 + 5) & 11'h7FF);
      wr(ADDR_W'(i), v);
      push_issue(v, ADDR_W'(i), i + 1);
    end
    done_q.push_back(17);
    start_run(4'd15, 8'd1);
    wait_idle("full_mem", 18);

    // 255 passes over a one-word program (mem[0] = 5).
    for (int i = 1; i <= 255; i++) push_issue(11'h005, 4'd0, i);
    done_q.push_back(256);
    start_run(4'd0, 8'd255);
    wait_idle("iter255", 257);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
